// File: rtl/pipe_rr_sched.sv
// Round-robin / fixed-priority scheduler feeding a shared two-stage OR datapath.
// Aligns each winner's A operand with stage 1 and returns the tagged result two cycles later.
module pipe_rr_sched #(
    parameter int NREQ = 4,
    parameter int W    = 1,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_d,
    input  logic [NREQ*W-1:0] op_a,
    input  logic              rr_en,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      pipe_d,
    output logic [W-1:0]      pipe_a,
    input  logic [W-1:0]      pipe_y,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic [W-1:0]      resp_data,
    output logic              busy
);

    logic [IDW-1:0]  r_ptr;
    logic [W-1:0]    r_a_hold;
    logic            r_v1;
    logic            r_v2;
    logic [IDW-1:0]  r_id1;
    logic [IDW-1:0]  r_id2;

    logic [NREQ-1:0] w_scan;
    logic [IDW-1:0]  w_base;
    logic [IDW-1:0]  w_off;
    logic [IDW:0]    w_sum;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_ptr_nxt;
    logic            w_issue;
    logic [W-1:0]    w_opa;

    // Rotate requests so the scan always starts at bit 0, then undo the rotation.
    always_comb begin
        w_base = rr_en ? r_ptr : '0;
        w_scan = rr_en ? NREQ'({req, req} >> r_ptr) : req;
        w_off  = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (w_scan[j]) begin
                w_off = IDW'(j);
            end
        end
        w_sum = {1'b0, w_base} + {1'b0, w_off};
        if (w_sum >= (IDW+1)'(NREQ)) begin
            w_sum = w_sum - (IDW+1)'(NREQ);
        end
        w_win     = w_sum[IDW-1:0];
        w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
        w_issue   = rst && (|req);
    end

    always_comb begin
        gnt    = '0;
        pipe_d = '0;
        w_opa  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_issue && (w_win == IDW'(i))) begin
                gnt[i] = 1'b1;
                pipe_d = op_d[i*W +: W];
                w_opa  = op_a[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr    <= '0;
            r_a_hold <= '0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_id1    <= '0;
            r_id2    <= '0;
        end else begin
            r_a_hold <= w_issue ? w_opa : '0;
            r_v1     <= w_issue;
            r_id1    <= w_issue ? w_win : '0;
            r_v2     <= r_v1;
            r_id2    <= r_id1;
            if (w_issue && rr_en) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign pipe_a     = r_a_hold;
    assign resp_valid = r_v2;
    assign resp_id    = r_id2;
    assign resp_data  = pipe_y;
    assign busy       = r_v1 | r_v2;

endmodule

// File: tb/tb_pipe_rr_sched.sv
// Bench for pipe_rr_sched: models the external OR datapath, checks grants
// directly and matches responses against a queue of hand-computed results.
module tb_pipe_rr_sched;

    localparam int NREQ = 4;
    localparam int W    = 1;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] op_d;
    logic [NREQ*W-1:0] op_a;
    logic              rr_en;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      pipe_d;
    logic [W-1:0]      pipe_a;
    logic [W-1:0]      pipe_y;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_data;
    logic              busy;

    logic [W-1:0]      dp_c;

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pipe_rr_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .op_d       (op_d),
        .op_a       (op_a),
        .rr_en      (rr_en),
        .gnt        (gnt),
        .pipe_d     (pipe_d),
        .pipe_a     (pipe_a),
        .pipe_y     (pipe_y),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External datapath: c <= D ; y <= c | A
    always @(posedge clk) begin
        if (!rst) begin
            dp_c   <= '0;
            pipe_y <= '0;
        end else begin
            dp_c   <= pipe_d;
            pipe_y <= dp_c | pipe_a;
        end
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req_v, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp id=%0d data=%0h t=%0t", resp_id, resp_data, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_id", 32'(resp_id), 32'(e.id));
                chk("resp_data", 32'(resp_data), e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] r, input logic [3:0] d, input logic [3:0] a,
                         input int k, input logic ed, input bit push);
        req  = r;
        op_d = d;
        op_a = a;
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(1) << k);
        chk("pipe_d", 32'(pipe_d), 32'(d[k]));
        if (push) begin
            exp_q.push_back('{id: k, data: 32'(ed)});
        end
        step();
    endtask

    task automatic drain();
        req = '0;
        repeat (3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst   = 1'b0;
        req   = 4'b1111;
        op_d  = 4'b1111;
        op_a  = 4'b1111;
        rr_en = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_pipe_d", 32'(pipe_d), 0);
        chk("rst_pipe_a", 32'(pipe_a), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_id", 32'(resp_id), 0);
        chk("rst_busy", 32'(busy), 0);
        req  = '0;
        op_d = '0;
        op_a = '0;
        step();
        rst = 1'b1;

        // single request
        issue(4'b0001, 4'b0001, 4'b0000, 0, 1'b1, 1'b1);
        req = '0;
        @(negedge clk);
        chk("single_pipe_a", 32'(pipe_a), 0);
        chk("single_busy_t1", 32'(busy), 1);
        step();
        @(negedge clk);
        chk("single_busy_t2", 32'(busy), 1);
        chk("single_valid_t2", 32'(resp_valid), 1);
        step();
        @(negedge clk);
        chk("single_busy_t3", 32'(busy), 0);
        step();

        // round-robin fairness from reset
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int n = 0; n < 8; n++) begin
            logic [3:0] dv;
            logic [3:0] av;
            dv = 4'b0011;
            av = 4'b0100;
            issue(4'b1111, dv, av, n % 4, dv[n % 4] | av[n % 4], 1'b1);
        end
        drain();

        // operand alignment, back-to-back
        issue(4'b0001, 4'b0000, 4'b0001, 0, 1'b1, 1'b1);
        issue(4'b0010, 4'b0010, 4'b0000, 1, 1'b1, 1'b1);
        issue(4'b0100, 4'b0000, 4'b0000, 2, 1'b0, 1'b1);
        drain();

        // ptr is 3 here; one grant to 1 leaves ptr=2
        issue(4'b0010, 4'b0000, 4'b0010, 1, 1'b1, 1'b1);

        // fixed priority, ptr frozen at 2
        rr_en = 1'b0;
        for (int n = 0; n < 3; n++) begin
            issue(4'b1010, 4'b1000, 4'b0010, 1, 1'b1, 1'b1);
        end
        issue(4'b1000, 4'b0000, 4'b0000, 3, 1'b0, 1'b1);
        issue(4'b1000, 4'b1000, 4'b0000, 3, 1'b1, 1'b1);
        rr_en = 1'b1;
        issue(4'b1010, 4'b0000, 4'b1000, 3, 1'b1, 1'b1);
        drain();

        // wrap-around: ptr 0 -> grant 2 -> ptr 3
        issue(4'b0100, 4'b0100, 4'b0000, 2, 1'b1, 1'b1);
        issue(4'b1001, 4'b1000, 4'b0000, 3, 1'b1, 1'b1);
        issue(4'b1001, 4'b0000, 4'b0001, 0, 1'b1, 1'b1);
        issue(4'b1001, 4'b0000, 4'b0000, 3, 1'b0, 1'b1);
        drain();

        // reset mid-operation: ptr is 0
        issue(4'b1111, 4'b1111, 4'b1111, 0, 1'b1, 1'b0);
        req  = 4'b1111;
        op_d = 4'b1111;
        op_a = 4'b1111;
        @(negedge clk);
        chk("midrst_gnt", 32'(gnt), 32'b0010);
        #1;
        rst = 1'b0;
        step();
        @(negedge clk);
        chk("midrst_valid_t2", 32'(resp_valid), 0);
        chk("midrst_busy_t2", 32'(busy), 0);
        chk("midrst_gnt_in_rst", 32'(gnt), 0);
        step();
        @(negedge clk);
        chk("midrst_valid_t3", 32'(resp_valid), 0);
        chk("midrst_busy_t3", 32'(busy), 0);
        step();
        rst = 1'b1;
        issue(4'b1111, 4'b0000, 4'b0000, 0, 1'b0, 1'b1);
        drain();

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
